// File: rtl/pool_window_sequencer_if.sv
// Handshake bundle between the window sequencer (master) and a 2x2 pooling responder (slave).
interface pool_window_sequencer_if;
  logic                  pool_start;
  logic [1:0][1:0][15:0] window_out;
  logic                  pool_finish;
  logic [15:0]           pool_pixel;

  modport master (output pool_start, window_out, input pool_finish, pool_pixel);
  modport slave  (input pool_start, window_out, output pool_finish, pool_pixel);
endinterface

// File: rtl/pool_window_sequencer.sv
// Walks a latched NxN map in 2x2 stride-2 windows, one responder handshake per window,
// collecting the returned pixels into an (N/2)x(N/2) map behind a single upstream handshake.
//
// state   | meaning
// IDLE    | waiting for start; latches image_in on acceptance
// ISSUE   | loads window_out for (row,col)
// WAIT_HI | pool_start high, waiting for pool_finish=1
// WAIT_LO | pool_start low, waiting for pool_finish=0, then advance
// DONE    | finish high until start is seen low
module pool_window_sequencer #(
  parameter int N = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [N-1:0][N-1:0][15:0]       image_in,
  output logic                            finish,
  output logic [N/2-1:0][N/2-1:0][15:0]   pooled_out,
  pool_window_sequencer_if.master         pw
);
  localparam int M  = N / 2;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [N-1:0][N-1:0][15:0] img_buf_q, img_buf_d;
  logic [CW-1:0]             row_q, row_d;
  logic [CW-1:0]             col_q, col_d;
  logic [1:0][1:0][15:0]     window_q, window_d;
  logic [M-1:0][M-1:0][15:0] pooled_q, pooled_d;
  logic                      pool_start_q, pool_start_d;
  logic                      finish_q, finish_d;
  logic [IW-1:0]             r0, r1, c0, c1;

  always_comb begin
    state_d      = state_q;
    img_buf_d    = img_buf_q;
    row_d        = row_q;
    col_d        = col_q;
    window_d     = window_q;
    pooled_d     = pooled_q;
    pool_start_d = pool_start_q;
    finish_d     = finish_q;
    r0 = IW'({row_q, 1'b0});
    c0 = IW'({col_q, 1'b0});
    r1 = r0 | IW'(1);
    c1 = c0 | IW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          img_buf_d = image_in;
          row_d     = '0;
          col_d     = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        window_d[0][0] = img_buf_q[r0][c0];
        window_d[0][1] = img_buf_q[r0][c1];
        window_d[1][0] = img_buf_q[r1][c0];
        window_d[1][1] = img_buf_q[r1][c1];
        pool_start_d   = 1'b1;
        state_d        = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (pw.pool_finish) begin
          pooled_d[row_q][col_q] = pw.pool_pixel;
          pool_start_d           = 1'b0;
          state_d                = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!pw.pool_finish) begin
          if (row_q == LAST && col_q == LAST) begin
            finish_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            if (col_q == LAST) begin
              col_d = '0;
              row_d = row_q + CW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        // Level start: a fresh run needs start to be seen low first.
        if (!start) begin
          finish_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      img_buf_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      window_q     <= '0;
      pooled_q     <= '0;
      pool_start_q <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      img_buf_q    <= img_buf_d;
      row_q        <= row_d;
      col_q        <= col_d;
      window_q     <= window_d;
      pooled_q     <= pooled_d;
      pool_start_q <= pool_start_d;
      finish_q     <= finish_d;
    end
  end

  assign finish        = finish_q;
  assign pooled_out    = pooled_q;
  assign pw.pool_start = pool_start_q;
  assign pw.window_out = window_q;
endmodule

// File: doc/pool_window_sequencer.md
# pool_window_sequencer

Initiator side of the pooling start/finish handshake. Latches an N×N feature map and walks it in non-overlapping 2×2 windows (stride 2), row-major. For each window it presents the four pixels to a 2×2 pooling responder, runs one start/finish handshake and stores the returned pixel in an (N/2)×(N/2) output map. Its own start/finish pair runs upstream to the layer controller, so a whole pooling layer becomes one handshake.

## Interface
- N, 4: input map dimension; must be even and ≥2. M = N/2 is the output dimension.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  level request from the layer controller; sampled only in IDLE.
- image_in  input  shortint [N-1:0][N-1:0]  input feature map; sampled only on the edge that accepts start.
- finish  output  1  high while in DONE.
- pooled_out  output  shortint [M-1:0][M-1:0]  result map; valid when finish=1.
- pool_start  output  1  handshake request to the pooling responder.
- window_out  output  shortint [1:0][1:0]  current window. Connect to the responder's image_in[1:0][1:0].
- pool_finish  input  1  responder done flag.
- pool_pixel  input  shortint  responder result.

## Operation
- All outputs are registered.
- Internal state: image buffer (N×N shortint), row and col counters ($clog2(M) bits, minimum 1), state register.
- States:
  - IDLE: when start=1, latch image_in into the buffer, set row=col=0, go to ISSUE.
  - ISSUE: window_out <= buf[2row+i][2col+j] for i,j in {0,1}. pool_start stays 0. Go to WAIT_HI unconditionally.
  - WAIT_HI: pool_start=1. When pool_finish=1: pooled_out[row][col] <= pool_pixel, pool_start <= 0, go to WAIT_LO. Otherwise hold.
  - WAIT_LO: pool_start=0. When pool_finish=0:
    - if row=M-1 and col=M-1, go to DONE;
    - else col++; on col=M-1, wrap col to 0 and row++; go to ISSUE.
  - Otherwise hold.
  - DONE: finish=1. When start=0: finish <= 0, go to IDLE.
- window_out is held constant from ISSUE through the end of WAIT_LO.
- The sequencer does no arithmetic on pixel data; pool_pixel is stored unmodified.
- Reset values: state=IDLE, finish=0, pool_start=0, window_out all 0, pooled_out all 0, counters 0, buffer all 0.
- Boundary conditions:
  - start dropping mid-run is ignored; the run completes, DONE is entered and finish pulses for one cycle.
  - start held high in DONE keeps finish high; no re-trigger until start has been seen low.
  - pool_finish=1 while in ISSUE (stale) has no effect.
  - pool_finish is only acted on in WAIT_HI and WAIT_LO.
  - A rising edge of rst in any state aborts immediately to reset values. Partial pooled_out is cleared.
  - A responder that never raises pool_finish leaves the block in WAIT_HI indefinitely. There is no timeout; the layer controller owns the watchdog.
  - image_in changes after acceptance do not affect the run.

## Timing
- With a zero-latency responder (pool_finish follows pool_start in the same cycle), each window takes exactly 3 cycles: ISSUE, WAIT_HI, WAIT_LO.
- Window k enters ISSUE at edge 3k, counted from the edge that accepts start (edge 0).
- finish rises after edge 3·M². For N=4 that is edge 12.
- A responder with latency L cycles adds L cycles in WAIT_HI and L in WAIT_LO per window.
- pooled_out[r][c] is written on the edge leaving WAIT_HI for window r·M+c. Earlier entries remain stable thereafter.
- Minimum gap: finish falls one edge after start is sampled low. A new start is accepted no earlier than the following edge.

## Test plan
- Reset: assert rst mid-run (in WAIT_HI of window 2), then release → finish=0, pool_start=0, pooled_out all 0, IDLE. A subsequent start runs a full pass.
- Basic, N=4, responder = 2×2 average (sum>>2), image[r][c]=4r+c, start held until finish → pooled_out = {{2,4},{10,12}}. finish rises 12 cycles after the start-accepting edge.
- Slow responder (pool_finish rises 3 cycles after pool_start and falls 2 cycles after it drops) → same pooled_out. Each window takes 1+4+3 cycles. window_out is stable during every handshake.
- Handshake protocol check: assertion that pool_start never rises while pool_finish=1, and that window_out never changes while pool_start=1. Run 100 random images at N=6 → results match the bench average model.
- Upstream level behaviour: start dropped at cycle 3 → run completes, finish high for one cycle. start held 10 cycles past finish → finish stays high, no second run. start is then lowered and raised → second run with new image_in.
- Stale/negative data: pool_finish forced to 1 when ISSUE is entered → no capture until WAIT_HI. Image all 16'h8000 with an averaging responder → pooled_out entries equal pool_pixel exactly (no sign alteration).
